branch_history_table: RTL and testbench

- Parametrised branch direction predictor for the dual-issue fetch stage.
- Replaces the single global 2-bit counter with a PC-indexed table of saturating counters. The table is looked up combinationally for both instructions of an 8-byte fetch group and trained by the EX stage when a branch resolves.
- Fetch uses pred_taken[0]/[1] in place of the old single predict bit when choosing the next PC and the issue mask.

---
 rtl/bp_pkg.sv | 34 +++
 rtl/bht_index_hash.sv | 27 ++
 rtl/branch_history_table.sv | 105 ++++++++++
 tb/tb_branch_history_table.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch direction predictor:
// counter encodings, reset value, saturating step and index sizing.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr2_e;

    localparam logic [1:0] WNT_INIT2 = WNT;

    // Weakly-not-taken for any counter width: MSB clear, all lower bits set.
    function automatic int unsigned wnt_init(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned sat_step(
        input int unsigned ctr,
        input logic        taken,
        input int unsigned ctr_max
    );
        if (taken) begin
            return (ctr >= ctr_max) ? ctr_max : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/bht_index_hash.sv
// PC word index, optionally XOR-folded with global history.
// Global history is mixed in only when BHT_GSHARE_EN is defined.
module bht_index_hash #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6
`ifdef BHT_GSHARE_EN
    ,
    parameter int GHR_W = 6
`endif
) (
    input  logic [PC_W-1:0]  pc,
`ifdef BHT_GSHARE_EN
    input  logic [GHR_W-1:0] ghr,
`endif
    output logic [IDX_W-1:0] idx
);

    logic unused_pc;
    assign unused_pc = ^{pc[PC_W-1:IDX_W+2], pc[1:0]};

`ifdef BHT_GSHARE_EN
    assign idx = pc[IDX_W+1:2] ^ IDX_W'(ghr);
`else
    assign idx = pc[IDX_W+1:2];
`endif

endmodule

// File: rtl/branch_history_table.sv
// PC-indexed table of saturating counters predicting both slots of a fetch group.
// Define BHT_GSHARE_EN to fold a resolve-time global history into every index.
module branch_history_table
    import bp_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic [1:0]       pred_taken,
    input  logic             update_valid,
    input  logic [PC_W-1:0]  update_pc,
    input  logic             update_taken,
    output logic [CTR_W-1:0] ctr_dbg
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam int unsigned CTR_MAX = (32'd1 << CTR_W) - 32'd1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(wnt_init(CTR_W));

    if (ENTRIES < 4 || (1 << IDX_W) != ENTRIES) begin : g_bad_entries
        $error("ENTRIES must be a power of 2 and at least 4");
    end
    if (CTR_W < 1) begin : g_bad_ctr
        $error("CTR_W must be at least 1");
    end
    if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr
        $error("GHR_W must be between 1 and IDX_W");
    end

    logic [CTR_W-1:0] table_q [ENTRIES];
    logic [PC_W-1:0]  base0;
    logic [PC_W-1:0]  base1;
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;
    logic [IDX_W-1:0] idx_u;
    logic             unused_low;

    assign unused_low = ^lookup_pc[2:0];
    assign base0 = {lookup_pc[PC_W-1:3], 3'b000};
    assign base1 = base0 + PC_W'(4);

`ifdef BHT_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    bht_index_hash #(.PC_W(PC_W), .IDX_W(IDX_W), .GHR_W(GHR_W)) u_hash_s0 (
        .pc  (base0),
        .ghr (ghr_q),
        .idx (idx0)
    );
    bht_index_hash #(.PC_W(PC_W), .IDX_W(IDX_W), .GHR_W(GHR_W)) u_hash_s1 (
        .pc  (base1),
        .ghr (ghr_q),
        .idx (idx1)
    );
    bht_index_hash #(.PC_W(PC_W), .IDX_W(IDX_W), .GHR_W(GHR_W)) u_hash_upd (
        .pc  (update_pc),
        .ghr (ghr_q),
        .idx (idx_u)
    );

    // History is trained only on resolved branches, so it never needs repair.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (update_valid) begin
            ghr_q <= GHR_W'({ghr_q, update_taken});
        end
    end
`else
    bht_index_hash #(.PC_W(PC_W), .IDX_W(IDX_W)) u_hash_s0 (
        .pc  (base0),
        .idx (idx0)
    );
    bht_index_hash #(.PC_W(PC_W), .IDX_W(IDX_W)) u_hash_s1 (
        .pc  (base1),
        .idx (idx1)
    );
    bht_index_hash #(.PC_W(PC_W), .IDX_W(IDX_W)) u_hash_upd (
        .pc  (update_pc),
        .idx (idx_u)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_INIT;
            end
        end else if (update_valid) begin
            table_q[idx_u] <= CTR_W'(sat_step(32'(table_q[idx_u]),
                                              update_taken, CTR_MAX));
        end
    end

    // No write bypass: a same-cycle lookup sees the pre-update counter.
    assign pred_taken[0] = table_q[idx0][CTR_W-1];
    assign pred_taken[1] = table_q[idx1][CTR_W-1];
    assign ctr_dbg       = table_q[idx_u];

endmodule

// File: tb/tb_branch_history_table.sv
// Directed self-checking bench for branch_history_table (default parameters).
module tb_branch_history_table;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic [1:0]  pred_taken;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [1:0]  ctr_dbg;

    int n_checks;
    int n_fail;

    branch_history_table dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (lookup_pc),
        .pred_taken   (pred_taken),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_taken (update_taken),
        .ctr_dbg      (ctr_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic t);
        update_valid = 1'b1;
        update_pc    = pc;
        update_taken = t;
        cycle();
        update_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        lookup_pc = 32'h100;
        update_pc = 32'h100;
        #1;
        n_checks++;
        if (pred_taken !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pred: got %b expected 00", pred_taken);
        end
        n_checks++;
        if (ctr_dbg !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_ctr: got %b expected 01", ctr_dbg);
        end
    endtask

    task automatic test_slot1();
        logic [1:0] exp_ctr [2];
        exp_ctr[0] = 2'b10;
        exp_ctr[1] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            train(32'h104, 1'b1);
            lookup_pc = 32'h100;
            update_pc = 32'h104;
            #1;
            n_checks++;
            if (ctr_dbg !== exp_ctr[i]) begin
                n_fail++;
                $display("FAIL slot1_ctr[%0d]: got %b expected %b",
                         i, ctr_dbg, exp_ctr[i]);
            end
            n_checks++;
            if (pred_taken !== 2'b10) begin
                n_fail++;
                $display("FAIL slot1_pred[%0d]: got %b expected 10",
                         i, pred_taken);
            end
        end
        update_pc = 32'h100;
        #1;
        n_checks++;
        if (ctr_dbg !== 2'b01) begin
            n_fail++;
            $display("FAIL slot0_untouched: got %b expected 01", ctr_dbg);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_t [5];
        logic [1:0] exp_n [4];
        exp_t[0] = 2'b10; exp_t[1] = 2'b11; exp_t[2] = 2'b11;
        exp_t[3] = 2'b11; exp_t[4] = 2'b11;
        exp_n[0] = 2'b10; exp_n[1] = 2'b01; exp_n[2] = 2'b00;
        exp_n[3] = 2'b00;
        lookup_pc = 32'h20;
        for (int i = 0; i < 5; i++) begin
            train(32'h20, 1'b1);
            #1;
            n_checks++;
            if (ctr_dbg !== exp_t[i]) begin
                n_fail++;
                $display("FAIL sat_up[%0d]: got %b expected %b",
                         i, ctr_dbg, exp_t[i]);
            end
        end
        n_checks++;
        if (pred_taken[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pred_t: got %b expected 1", pred_taken[0]);
        end
        for (int i = 0; i < 4; i++) begin
            train(32'h20, 1'b0);
            #1;
            n_checks++;
            if (ctr_dbg !== exp_n[i]) begin
                n_fail++;
                $display("FAIL sat_down[%0d]: got %b expected %b",
                         i, ctr_dbg, exp_n[i]);
            end
        end
        update_taken = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (ctr_dbg !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_hold: got %b expected 00", ctr_dbg);
        end
        n_checks++;
        if (pred_taken[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_pred_n: got %b expected 0", pred_taken[0]);
        end
    endtask

    task automatic test_same_cycle();
        lookup_pc    = 32'h40;
        update_valid = 1'b1;
        update_pc    = 32'h40;
        update_taken = 1'b1;
        #1;
        n_checks++;
        if (pred_taken[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_old: got %b expected 0", pred_taken[0]);
        end
        cycle();
        update_valid = 1'b0;
        #1;
        n_checks++;
        if (pred_taken[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_new: got %b expected 1", pred_taken[0]);
        end
    endtask

    task automatic test_wrap_top();
        train(32'hFFFF_FFFC, 1'b1);
        lookup_pc = 32'hFFFF_FFFC;
        #1;
        n_checks++;
        if (pred_taken !== 2'b10) begin
            n_fail++;
            $display("FAIL top_of_space: got %b expected 10", pred_taken);
        end
    endtask

    task automatic test_alias_and_reset();
        train(32'h000, 1'b1);
        train(32'h000, 1'b1);
        lookup_pc = 32'h100;
        #1;
        n_checks++;
        if (pred_taken !== 2'b11) begin
            n_fail++;
            $display("FAIL alias_pred: got %b expected 11", pred_taken);
        end
        rst          = 1'b1;
        update_valid = 1'b1;
        update_pc    = 32'h104;
        update_taken = 1'b1;
        cycle();
        rst          = 1'b0;
        update_valid = 1'b0;
        #1;
        n_checks++;
        if (ctr_dbg !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_drops_update: got %b expected 01", ctr_dbg);
        end
        n_checks++;
        if (pred_taken !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_pred: got %b expected 00", pred_taken);
        end
        update_pc = 32'h20;
        #1;
        n_checks++;
        if (ctr_dbg !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_ctr_20: got %b expected 01", ctr_dbg);
        end
        update_pc = 32'h40;
        #1;
        n_checks++;
        if (ctr_dbg !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_ctr_40: got %b expected 01", ctr_dbg);
        end
    endtask

    task automatic test_history();
        logic [1:0] exp_pred;
        logic [1:0] exp_ctr;
`ifdef BHT_GSHARE_EN
        exp_pred = 2'b00;
        exp_ctr  = 2'b01;
`else
        exp_pred = 2'b01;
        exp_ctr  = 2'b11;
`endif
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        train(32'h0, 1'b1);
        train(32'h0, 1'b1);
        lookup_pc = 32'h0;
        update_pc = 32'h0;
        #1;
        n_checks++;
        if (pred_taken !== exp_pred) begin
            n_fail++;
            $display("FAIL history_pred: got %b expected %b",
                     pred_taken, exp_pred);
        end
        n_checks++;
        if (ctr_dbg !== exp_ctr) begin
            n_fail++;
            $display("FAIL history_ctr: got %b expected %b", ctr_dbg, exp_ctr);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        lookup_pc    = '0;
        update_valid = 1'b0;
        update_pc    = '0;
        update_taken = 1'b0;
        test_reset();
        test_slot1();
        test_saturation();
        test_same_cycle();
        test_wrap_top();
        test_alias_and_reset();
        test_history();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
